// File: rtl/tone_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_detect_pkg
// Description : Shared types, constants and helpers for the tone frequency
//               detector (detector states, default thresholds, scaling).
// Revision    : 1.0 - initial release
// ============================================================================
package tone_detect_pkg;

    // Crossing detector states: armed when waiting for the high side
    typedef enum logic [0:0] {
        WAIT_LOW  = 1'b0,
        WAIT_HIGH = 1'b1
    } det_state_t;

    localparam int         SAMPLE_RATE  = 32000;
    localparam logic [7:0] DEFAULT_LOW  = 8'd112;
    localparam logic [7:0] DEFAULT_HIGH = 8'd144;
    localparam int         FREQ_MAX     = 16383;

    // Converts a crossing count to Hz (count << shift), clamped to 14 bits
    function automatic logic [13:0] scale_freq(input logic [10:0] crosses,
                                               input int          shift);
        logic [31:0] wide;
        wide = 32'(crosses) << shift;
        if (wide > 32'(FREQ_MAX)) begin
            return 14'(FREQ_MAX);
        end
        return wide[13:0];
    endfunction

endpackage : tone_detect_pkg
`default_nettype wire

// File: rtl/tone_window_stats.sv
`default_nettype none
// ============================================================================
// Module      : tone_window_stats
// Description : Per-window min/max tracking of valid samples and derivation
//               of the adaptive crossing thresholds applied to the next
//               window. The swing of the window being closed is exposed
//               combinationally so the top level can qualify its result.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_window_stats
    import tone_detect_pkg::*;
#(
    parameter int MIN_SWING = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    input  logic       window_close,
    output logic [7:0] low_thresh,
    output logic [7:0] high_thresh,
    output logic [7:0] swing
);

    localparam logic [8:0] c_min_swing = 9'(MIN_SWING);

    logic [7:0] r_min;
    logic [7:0] r_max;
    logic [7:0] r_low;
    logic [7:0] r_high;

    logic [7:0] w_min_inc;
    logic [7:0] w_max_inc;
    logic [7:0] w_swing;
    logic [8:0] w_sum;
    logic [7:0] w_mid;
    logic [7:0] w_hyst;
    logic [7:0] w_low_new;
    logic [7:0] w_high_new;
    logic       w_too_small;

    // Window extremes including the current sample, and threshold arithmetic
    always_comb begin
        w_min_inc = r_min;
        w_max_inc = r_max;
        if (sample_valid && (sample < r_min)) begin
            w_min_inc = sample;
        end
        if (sample_valid && (sample > r_max)) begin
            w_max_inc = sample;
        end
        // max >= min always holds here because the closing sample is valid
        w_swing     = w_max_inc - w_min_inc;
        w_sum       = {1'b0, w_min_inc} + {1'b0, w_max_inc};
        w_mid       = w_sum[8:1];
        w_hyst      = {3'b000, w_swing[7:3]};
        // mid - swing/8 stays >= min and mid + swing/8 stays <= max
        w_low_new   = w_mid - w_hyst;
        w_high_new  = w_mid + w_hyst;
        w_too_small = ({1'b0, w_swing} < c_min_swing);
    end

    // Extremes restart each window; thresholds latch at window close
    always_ff @(posedge clk) begin
        if (rst) begin
            r_min  <= 8'd255;
            r_max  <= 8'd0;
            r_low  <= DEFAULT_LOW;
            r_high <= DEFAULT_HIGH;
        end else if (sample_valid && window_close) begin
            r_min <= 8'd255;
            r_max <= 8'd0;
            if (w_too_small) begin
                r_low  <= DEFAULT_LOW;
                r_high <= DEFAULT_HIGH;
            end else begin
                r_low  <= w_low_new;
                r_high <= w_high_new;
            end
        end else if (sample_valid) begin
            r_min <= w_min_inc;
            r_max <= w_max_inc;
        end
    end

    assign low_thresh  = r_low;
    assign high_thresh = r_high;
    assign swing       = w_swing;

endmodule : tone_window_stats
`default_nettype wire

// File: rtl/tone_frequency_detector.sv
`default_nettype none
// ============================================================================
// Module      : tone_frequency_detector
// Description : Measures the fundamental frequency of an 8-bit tone stream by
//               counting hysteresis-qualified rising crossings over a gate
//               window of valid samples; reports Hz and a tone-present flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_frequency_detector
    import tone_detect_pkg::*;
#(
    parameter int GATE_SHIFT = 3,
    parameter int MIN_SWING  = 16
) (
    input  logic        CLK_32KHz,
    input  logic        reset,
    input  logic [7:0]  inputSample,
    input  logic        inputSampleValid,
    output logic [13:0] measuredFrequency,
    output logic        toneDetected,
    output logic        resultValid
);

    localparam int          c_gate      = SAMPLE_RATE >> GATE_SHIFT;
    localparam logic [14:0] c_last      = 15'(c_gate - 1);
    localparam logic [8:0]  c_min_swing = 9'(MIN_SWING);

    det_state_t  r_state;
    det_state_t  w_state_next;
    logic        w_crossing;

    logic [14:0] r_win_cnt;
    logic [10:0] r_cross;
    logic [10:0] w_cross_inc;
    logic        w_close;

    logic [7:0]  w_low_thresh;
    logic [7:0]  w_high_thresh;
    logic [7:0]  w_swing;
    logic        w_present;
    logic [13:0] w_freq;
    logic        w_detect;

    logic [13:0] r_freq;
    logic        r_detect;
    logic        r_result_valid;

    tone_window_stats #(
        .MIN_SWING (MIN_SWING)
    ) u_stats (
        .clk          (CLK_32KHz),
        .rst          (reset),
        .sample       (inputSample),
        .sample_valid (inputSampleValid),
        .window_close (w_close),
        .low_thresh   (w_low_thresh),
        .high_thresh  (w_high_thresh),
        .swing        (w_swing)
    );

    // The last valid sample of the gate closes the window on its own edge
    assign w_close = inputSampleValid && (r_win_cnt == c_last);

    // Crossing detector state register; never cleared at window boundaries
    always_ff @(posedge CLK_32KHz) begin
        if (reset) begin
            r_state <= WAIT_LOW;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Hysteresis crossing detection: arm on low side, count on high side
    always_comb begin
        w_state_next = r_state;
        w_crossing   = 1'b0;
        if (inputSampleValid) begin
            case (r_state)
                WAIT_LOW: begin
                    if (inputSample <= w_low_thresh) begin
                        w_state_next = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (inputSample >= w_high_thresh) begin
                        w_state_next = WAIT_LOW;
                        w_crossing   = 1'b1;
                    end
                end
                default: begin
                    w_state_next = WAIT_LOW;
                end
            endcase
        end
    end

    // Crossing count including the current sample, and the window result
    always_comb begin
        w_cross_inc = r_cross;
        if (w_crossing && (r_cross != 11'h7FF)) begin
            w_cross_inc = r_cross + 11'd1;
        end
        w_present = ({1'b0, w_swing} >= c_min_swing);
        w_freq    = w_present ? scale_freq(w_cross_inc, GATE_SHIFT) : 14'd0;
        w_detect  = w_present && (w_cross_inc != 11'd0);
    end

    // Window sample counter and crossing counter, advanced by valid samples only
    always_ff @(posedge CLK_32KHz) begin
        if (reset) begin
            r_win_cnt <= 15'd0;
            r_cross   <= 11'd0;
        end else if (inputSampleValid) begin
            if (w_close) begin
                r_win_cnt <= 15'd0;
                r_cross   <= 11'd0;
            end else begin
                r_win_cnt <= r_win_cnt + 15'd1;
                r_cross   <= w_cross_inc;
            end
        end
    end

    // Result registers update only at window close; pulse follows that edge
    always_ff @(posedge CLK_32KHz) begin
        if (reset) begin
            r_freq         <= 14'd0;
            r_detect       <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_close;
            if (w_close) begin
                r_freq   <= w_freq;
                r_detect <= w_detect;
            end
        end
    end

    assign measuredFrequency = r_freq;
    assign toneDetected      = r_detect;
    assign resultValid       = r_result_valid;

endmodule : tone_frequency_detector
`default_nettype wire

// File: tb/tb_tone_frequency_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_frequency_detector
// Description : Self-checking bench for tone_frequency_detector. Tone cases
//               come from a vector table; each window close pushes its
//               expected result to a queue that a monitor pops on resultValid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_frequency_detector;

    localparam int GATE = 4000;

    logic        clk;
    logic        reset;
    logic [7:0]  inputSample;
    logic        inputSampleValid;
    logic [13:0] measuredFrequency;
    logic        toneDetected;
    logic        resultValid;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    string  cur_name = "init";

    typedef struct {
        int     freq;
        bit     det;
        longint due;
    } exp_t;

    exp_t q[$];

    // Tone case: sample = base + round(amp/2 * (1 - cos)), i.e. starting at
    // its trough so every period's rising edge lies inside the window.
    typedef struct {
        string name;
        int    hz;
        int    base;
        int    amp;
        bit    half;
        int    windows;
        int    w1_freq;
        bit    w1_det;
        int    wn_freq;
        bit    wn_det;
    } vec_t;

    tone_frequency_detector #(
        .GATE_SHIFT (3),
        .MIN_SWING  (16)
    ) dut (
        .CLK_32KHz         (clk),
        .reset             (reset),
        .inputSample       (inputSample),
        .inputSampleValid  (inputSampleValid),
        .measuredFrequency (measuredFrequency),
        .toneDetected      (toneDetected),
        .resultValid       (resultValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s [%s] actual=%0d expected=%0d", name, cur_name, act, exp);
        end
    endtask

    function automatic int gen(input int hz, input int base, input int amp, input int n);
        real ph;
        ph = 2.0 * 3.14159265358979 * real'(hz) * real'(n) / 32000.0;
        return base + $rtoi(real'(amp) / 2.0 * (1.0 - $cos(ph)) + 0.5);
    endfunction

    // Scoreboard monitor: every pulse must match the oldest expectation
    always @(negedge clk) begin
        if (resultValid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse [%s] actual=1 expected=0 cycle=%0d", cur_name, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_cycle", cyc, e.due);
                check("frequency", longint'(measuredFrequency), longint'(e.freq));
                check("tone_detected", longint'(toneDetected), longint'(e.det));
            end
        end
    end

    // Drives nvalid valid samples of a tone; optionally expects a result after the last
    task automatic drive_window(input int hz, input int base, input int amp, input bit half,
                                input int nvalid, input bit push, input int ef, input bit ed,
                                inout int n);
        int cnt;
        bit vld;
        cnt = 0;
        while (cnt < nvalid) begin
            @(negedge clk);
            vld              = !half || (n % 2 == 0);
            reset            = 1'b0;
            inputSample      = 8'(gen(hz, base, amp, n));
            inputSampleValid = vld;
            if (vld) begin
                cnt++;
                if (push && cnt == nvalid) begin
                    q.push_back('{ef, ed, cyc + 1});
                end
            end
            n++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        inputSampleValid = 1'b0;
        repeat (4) @(negedge clk);
        check("pending_results", longint'(q.size()), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_freq"}, longint'(measuredFrequency), 0);
        check({tag, "_det"}, longint'(toneDetected), 0);
        check({tag, "_valid"}, longint'(resultValid), 0);
    endtask

    // One reset cycle, with a valid sample offered to show it is ignored
    task automatic reset_dut();
        @(negedge clk);
        reset            = 1'b1;
        inputSampleValid = 1'b1;
        inputSample      = 8'd0;
        @(negedge clk);
        check_zero_outputs("reset");
        reset            = 1'b0;
        inputSampleValid = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        int n;

        // 1000 Hz / 440 Hz: 125 / 55 whole periods per 125 ms window.
        // Scaled tone (0..40): defaults 112/144 are never reached upward in
        // window 1; window 2 uses 15/25 from min 0 / max 40.
        // Half-rate: 4000 valid samples span 250 ms = 250 periods.
        vecs[0] = '{"sine_1000", 1000, 0,   255, 1'b0, 2, 1000, 1'b1, 1000, 1'b1};
        vecs[1] = '{"sine_440",  440,  0,   255, 1'b0, 2, 440,  1'b1, 440,  1'b1};
        vecs[2] = '{"scaled_40", 1000, 0,   40,  1'b0, 2, 0,    1'b0, 1000, 1'b1};
        vecs[3] = '{"const_128", 0,    128, 0,   1'b0, 2, 0,    1'b0, 0,    1'b0};
        vecs[4] = '{"half_rate", 1000, 0,   255, 1'b1, 1, 2000, 1'b1, 2000, 1'b1};

        reset            = 1'b1;
        inputSample      = 8'd0;
        inputSampleValid = 1'b0;
        repeat (2) @(negedge clk);
        cur_name = "power_on";
        check_zero_outputs("power_on_reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            cur_name = vecs[i].name;
            reset_dut();
            n = 0;
            for (int w = 0; w < vecs[i].windows; w++) begin
                drive_window(vecs[i].hz, vecs[i].base, vecs[i].amp, vecs[i].half, GATE, 1'b1,
                             (w == 0) ? vecs[i].w1_freq : vecs[i].wn_freq,
                             (w == 0) ? vecs[i].w1_det  : vecs[i].wn_det, n);
            end
            drain();
        end

        // Reset mid-window: the partial window must be discarded without a
        // pulse; the tone source restarts at its trough with the detector.
        cur_name = "mid_reset";
        reset_dut();
        n = 0;
        drive_window(1000, 0, 255, 1'b0, GATE, 1'b1, 1000, 1'b1, n);
        drive_window(1000, 0, 255, 1'b0, 2000, 1'b0, 0, 1'b0, n);
        @(negedge clk);
        reset            = 1'b1;
        inputSampleValid = 1'b1;
        inputSample      = 8'(gen(1000, 0, 255, n));
        @(negedge clk);
        check_zero_outputs("mid_reset");
        check("mid_reset_queue", longint'(q.size()), 0);
        reset            = 1'b0;
        inputSampleValid = 1'b0;
        n = 0;
        drive_window(1000, 0, 255, 1'b0, GATE, 1'b1, 1000, 1'b1, n);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #(10 * 200000);
        $display("FAIL watchdog [%s] actual=timeout expected=finish", cur_name);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_tone_frequency_detector
`default_nettype wire

// File: doc/tone_frequency_detector.md
# tone_frequency_detector

Measures the fundamental frequency of an incoming unsigned 8-bit tone sample stream at the 32 kHz sample rate, inverting the job of the sine signal generator. It counts hysteresis-qualified rising midpoint crossings over a fixed gate window and reports the result in Hz. Crossing thresholds adapt to the signal's measured min/max, so amplitude-scaled tones whose centre sits below 128 are still detected. It sits downstream of the tone generator/mixer, feeding self-test and tuner logic.

## Interface
- GATE_SHIFT, 3: gate window = 32000 >> GATE_SHIFT valid samples (default 4000 samples = 125 ms); frequency LSB = 2^GATE_SHIFT Hz.
- MIN_SWING, 16: minimum window (max − min) for a tone to count as present.
- CLK_32KHz  in  1  sample clock.
- reset  in  1  synchronous, active-high reset.
- inputSample  in  8  unsigned sample, 0–255.
- inputSampleValid  in  1  sample qualifier; only samples with this high are processed or counted.
- measuredFrequency  out  14  last window's frequency in Hz; reset 0.
- toneDetected  out  1  last window had enough swing and at least one crossing; reset 0.
- resultValid  out  1  one-cycle pulse when measuredFrequency and toneDetected update; reset 0.

## Operation
- Detector FSM states are WAIT_LOW and WAIT_HIGH; reset state is WAIT_LOW.
- WAIT_LOW → WAIT_HIGH on a valid sample ≤ lowThresh.
- WAIT_HIGH → WAIT_LOW on a valid sample ≥ highThresh; this transition increments crossCount (11 bits, saturates at 2047).
- FSM state is never cleared at a window boundary, so a crossing spanning two windows is not lost.
- Stats per window: minS (reset 255) and maxS (reset 0) track valid samples.
- At window close, using the min/max including the closing sample:
  - swing = maxS − minS.
  - mid = (minS + maxS) >> 1, computed with a 9-bit sum.
  - hyst = swing >> 3.
  - New thresholds are lowThresh = mid − hyst and highThresh = mid + hyst; underflow and overflow cannot occur.
- If swing < MIN_SWING, thresholds revert to the defaults 112/144.
- Thresholds from reset: 112/144.
- Outputs at window close:
  - measuredFrequency = crossCount << GATE_SHIFT, saturated to 16383; forced to 0 when swing < MIN_SWING.
  - toneDetected = (swing ≥ MIN_SWING) && (crossCount ≠ 0).
- After window close, crossCount resets to 0, minS to 255, maxS to 0 and the window counter to 0.
- Window counter: counts valid samples from 0 to GATE−1. Idle cycles (inputSampleValid low) advance nothing.

## Timing
- Every valid sample is processed on the edge where it is presented.
- A crossing on the last sample of a window counts in the closing window.
- The last sample of a window also contributes to that window's min/max.
- resultValid is high for exactly the cycle after the edge that accepts sample GATE−1.
- measuredFrequency and toneDetected change only on that same edge and hold until the next window close.
- The first window's thresholds apply to samples 0..GATE−1. The new thresholds take effect from the first sample of the next window.
- Measurement latency is GATE valid samples plus 1 cycle.
- Reset asserted mid-window:
  - On the next edge, all state returns to reset values: outputs 0, FSM in WAIT_LOW, thresholds default, window counter 0.
  - The partial window is discarded and no resultValid pulse is generated.
- inputSampleValid is ignored while reset is high.

## Structure
- Package tone_detect_pkg holds:
  - the state enum typedef (WAIT_LOW, WAIT_HIGH);
  - SAMPLE_RATE = 32000;
  - DEFAULT_LOW = 112 and DEFAULT_HIGH = 144;
  - FREQ_MAX = 16383.
- Sub-module tone_window_stats holds the min/max trackers and the mid/hyst/threshold arithmetic. It exposes the registered thresholds and the swing.
- The top level keeps the FSM, the window counter, crossCount and the output registers.

## Test plan
- 1000 Hz full-amplitude sine (phase step 1000/32000, 8-bit, 0–255), valid every cycle → every resultValid gives measuredFrequency = 1000, toneDetected = 1, with pulses 4000 cycles apart.
- 440 Hz full-amplitude sine → measuredFrequency = 440 (55 crossings × 8) from the second window on.
- 1000 Hz sine scaled to peak 40 (centre ≈ 20) → window 1: measuredFrequency = 0, toneDetected = 0 (the default thresholds are never crossed); window 2 onward: 1000, toneDetected = 1.
- Constant 128 input → swing = 0, so each window reports measuredFrequency = 0 and toneDetected = 0.
- 1000 Hz sine with inputSampleValid low every other cycle (16 kHz effective rate) → resultValid every 8000 cycles, measuredFrequency = 2000.
- Reset for 1 cycle at sample 2000 of a window → outputs 0 on the next edge. The next resultValid arrives 4000 valid samples after reset release, reporting the correct frequency (1000 for the 1000 Hz stimulus).
